adc_scheduler: RTL and testbench
================================

Name: adc_scheduler

Overview:
- Time-shares the single external 4-bit-bus ADC among three requesters:
  - ch0 = oven temperature probe
  - ch1 = set-temperature potentiometer
  - ch2 = set-time potentiometer
- Round-robin arbitration; drives the analog mux select and the ADC WR/RD/CS strobes.
- Assembles each 8-bit result from two nibble reads and returns it tagged with the channel.
- Sits between the oven FSM/timer consumers and the ADC pins; replaces free-running enable gating with explicit sequencing.

Parameters:
- MUX_SETTLE, 2, cycles CS low with mux select stable before WR.
- WR_WIDTH, 4, cycles adc_wr_n held low.
- RD_WIDTH, 2, cycles adc_rd_n held low per nibble; data sampled on last cycle.
- CONV_TIMEOUT, 1000, max cycles in WAIT before abort (counter width = clog2(CONV_TIMEOUT+1)).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  permits new arbitration
- req  in  3  per-channel level request; held until own result_valid
- adc_int  in  1  ADC end-of-conversion, active low, asynchronous
- adc_data  in  4  ADC nibble bus
- clear_err  in  1  clears timeout_err
- adc_cs_n  out  1  ADC chip select, active low
- adc_wr_n  out  1  start-conversion strobe, active low
- adc_rd_n  out  1  read strobe, active low
- adc_sel  out  2  analog mux channel (0..2)
- grant  out  3  one-hot, active channel for whole transaction
- result  out  8  {high nibble, low nibble}
- result_ch  out  2  channel of result
- result_valid  out  1  one-cycle pulse
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky conversion-timeout flag

Behaviour:
- Reset (async, immediate): adc_cs_n=1, adc_wr_n=1, adc_rd_n=1, adc_sel=0, grant=0, result=0, result_ch=0, result_valid=0, busy=0, timeout_err=0, rr pointer = last-served 2 (so ch0 wins first), FSM=IDLE, int sync flops=1.
- adc_int passes through a 2-flop synchronizer; int_s is the synced value (2-cycle latency).
- States:
  - IDLE:
    - Exit when enable=1, |req, and int_s=1 (ADC idle).
    - Winner = first requesting channel after last-served, cyclic 0→1→2→0.
    - Next edge: grant, adc_sel, and adc_cs_n=0 registered; -> SETTLE.
  - SETTLE: MUX_SETTLE cycles -> WR.
  - WR: adc_wr_n=0 for WR_WIDTH cycles -> WAIT; timeout counter cleared.
  - WAIT:
    - int_s=0 -> RD_HI.
    - Counter reaches CONV_TIMEOUT -> ABORT.
  - RD_HI: adc_rd_n=0 for RD_WIDTH cycles; adc_data captured to hi on last -> GAP.
  - GAP: one cycle, adc_rd_n=1 -> RD_LO.
  - RD_LO: adc_rd_n=0 for RD_WIDTH cycles; lo captured on last -> DONE.
  - DONE (one cycle):
    - result={hi,lo}, result_ch=channel, result_valid=1.
    - Strobes high, cs_n=1, grant=0, pointer=channel -> IDLE.
  - ABORT (one cycle):
    - Strobes high, cs_n=1, grant=0, timeout_err=1, pointer=channel (no starvation).
    - No result_valid; result keeps old value -> IDLE.
- Latency IDLE-exit to result_valid = 1 + MUX_SETTLE + WR_WIDTH + wait + 2·RD_WIDTH + 1 + 1 cycles. wait = cycles in WAIT, ≥1.
- Boundary conditions:
  - enable falls mid-transaction: transaction completes; only new arbitration blocked.
  - req of granted channel falls mid-transaction: transaction completes; result_valid still pulses.
  - New req or changes of other reqs mid-transaction: ignored until IDLE.
  - clear_err and a new timeout in the same cycle: set wins.
  - int_s already 0 in IDLE (stuck ADC): no start; busy stays 0.
  - rst mid-operation: all outputs to reset values at once; no result_valid.
  - Back-to-back: at least one IDLE cycle between transactions; cs_n high ≥1 cycle.
  - adc_sel never changes while adc_cs_n=0.

Test Plan:
- Single req=001, ADC model pulls adc_int low 10 cycles after WR rise, data hi=0xA, lo=0x5 (defaults) -> result=0xA5, result_ch=0, one-cycle result_valid, wr_n low exactly 4 cycles, rd_n low 2+2 with 1-cycle gap.
- req=111 held continuously -> grant order ch0, ch1, ch2, ch0; each result_ch matches its grant; no channel served twice in a row.
- ADC never asserts adc_int -> ABORT after 1000 WAIT cycles, timeout_err=1, no result_valid. Next transaction serves the next channel in rotation. clear_err pulse -> timeout_err=0.
- rst asserted during RD_HI -> outputs immediately at reset values, result_valid stays 0. After release, req=010 -> transaction completes normally.
- enable dropped during WAIT with req=001 -> result_valid still pulses. No new transaction while enable=0 despite req=001. Resumes when enable=1.
- clear_err and timeout in the same cycle -> timeout_err=1.

Source files
------------

// File: rtl/adc_scheduler.sv
// Round-robin scheduler for one shared 4-bit-bus ADC: sequences the mux select and
// the CS/WR/RD strobes, then assembles each 8-bit result from two nibble reads.
module adc_scheduler #(
  parameter int MUX_SETTLE   = 2,
  parameter int WR_WIDTH     = 4,
  parameter int RD_WIDTH     = 2,
  parameter int CONV_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] req,
  input  logic       adc_int,
  input  logic [3:0] adc_data,
  input  logic       clear_err,
  output logic       adc_cs_n,
  output logic       adc_wr_n,
  output logic       adc_rd_n,
  output logic [1:0] adc_sel,
  output logic [2:0] grant,
  output logic [7:0] result,
  output logic [1:0] result_ch,
  output logic       result_valid,
  output logic       busy,
  output logic       timeout_err,
  output logic [3:0] dbg_state
);

  localparam int CW = $clog2(CONV_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SETTLE, S_WR, S_WAIT, S_RD_HI, S_GAP, S_RD_LO, S_DONE, S_ABORT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync1_q, sync2_q;
  logic [1:0]    last_q, last_d;
  logic [1:0]    sel_q, sel_d;
  logic [2:0]    grant_q, grant_d;
  logic [3:0]    hi_q, hi_d;
  logic [7:0]    result_q, result_d;
  logic [1:0]    result_ch_q, result_ch_d;
  logic          result_valid_q, result_valid_d;
  logic          timeout_err_q, timeout_err_d;
  logic          cs_n_q, cs_n_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d, busy_q, busy_d;
  logic          int_s;
  logic [1:0]    cand, win_ch;
  logic          win_found;

  assign int_s = sync2_q;

  // Handshake: req is a level held by its owner until its own result_valid;
  // result_valid is a one-cycle pulse with no back-pressure from the consumer.
  always_comb begin
    cand      = last_q;
    win_found = 1'b0;
    win_ch    = 2'd0;
    for (int k = 0; k < 3; k++) begin
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_ch    = cand;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q + CW'(1);
    last_d         = last_q;
    sel_d          = sel_q;
    grant_d        = grant_q;
    hi_d           = hi_q;
    result_d       = result_q;
    result_ch_d    = result_ch_q;
    result_valid_d = 1'b0;
    timeout_err_d  = clear_err ? 1'b0 : timeout_err_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (enable && win_found && int_s) begin
          state_d = S_SETTLE;
          sel_d   = win_ch;
          grant_d = 3'b001 << win_ch;
        end
      end
      S_SETTLE: if (cnt_q == CW'(MUX_SETTLE - 1)) begin
        state_d = S_WR;
        cnt_d   = '0;
      end
      S_WR: if (cnt_q == CW'(WR_WIDTH - 1)) begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (!int_s) begin
          state_d = S_RD_HI;
          cnt_d   = '0;
        end else if (cnt_q == CW'(CONV_TIMEOUT - 1)) begin
          // A set in the same cycle as clear_err must win, so it overrides the default.
          state_d       = S_ABORT;
          cnt_d         = '0;
          timeout_err_d = 1'b1;
          grant_d       = 3'b000;
          last_d        = sel_q;
        end
      end
      S_RD_HI: if (cnt_q == CW'(RD_WIDTH - 1)) begin
        state_d = S_GAP;
        cnt_d   = '0;
        hi_d    = adc_data;
      end
      S_GAP: begin
        state_d = S_RD_LO;
        cnt_d   = '0;
      end
      S_RD_LO: if (cnt_q == CW'(RD_WIDTH - 1)) begin
        state_d        = S_DONE;
        cnt_d          = '0;
        result_d       = {hi_q, adc_data};
        result_ch_d    = sel_q;
        result_valid_d = 1'b1;
        grant_d        = 3'b000;
        last_d         = sel_q;
      end
      S_DONE, S_ABORT: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Strobes are decoded from the next state so they leave a flop glitch-free.
    cs_n_d = (state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ABORT);
    wr_n_d = (state_d != S_WR);
    rd_n_d = !((state_d == S_RD_HI) || (state_d == S_RD_LO));
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      sync1_q        <= 1'b1;
      sync2_q        <= 1'b1;
      last_q         <= 2'd2;
      sel_q          <= 2'd0;
      grant_q        <= 3'b000;
      hi_q           <= 4'h0;
      result_q       <= 8'h00;
      result_ch_q    <= 2'd0;
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      cs_n_q         <= 1'b1;
      wr_n_q         <= 1'b1;
      rd_n_q         <= 1'b1;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sync1_q        <= adc_int;
      sync2_q        <= sync1_q;
      last_q         <= last_d;
      sel_q          <= sel_d;
      grant_q        <= grant_d;
      hi_q           <= hi_d;
      result_q       <= result_d;
      result_ch_q    <= result_ch_d;
      result_valid_q <= result_valid_d;
      timeout_err_q  <= timeout_err_d;
      cs_n_q         <= cs_n_d;
      wr_n_q         <= wr_n_d;
      rd_n_q         <= rd_n_d;
      busy_q         <= busy_d;
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_wr_n     = wr_n_q;
  assign adc_rd_n     = rd_n_q;
  assign adc_sel      = sel_q;
  assign grant        = grant_q;
  assign result       = result_q;
  assign result_ch    = result_ch_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign timeout_err  = timeout_err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_adc_scheduler.sv
// Directed bench for adc_scheduler: a behavioural ADC answers each conversion,
// and a linear sequence of steps checks arbitration, strobe timing and errors.
module tb_adc_scheduler;

  logic       clk = 1'b0;
  logic       rst, enable, clear_err;
  logic [2:0] req;
  logic       adc_int_model = 1'b1;
  logic       stuck_low = 1'b0;
  logic [3:0] adc_data = 4'h0;
  wire        adc_int = adc_int_model & ~stuck_low;
  logic       adc_cs_n, adc_wr_n, adc_rd_n, result_valid, busy, timeout_err;
  logic [1:0] adc_sel, result_ch;
  logic [2:0] grant;
  logic [7:0] result;
  logic [3:0] dbg_state;

  always #5 clk = ~clk;

  adc_scheduler dut (
    .clk(clk), .rst(rst), .enable(enable), .req(req), .adc_int(adc_int),
    .adc_data(adc_data), .clear_err(clear_err), .adc_cs_n(adc_cs_n),
    .adc_wr_n(adc_wr_n), .adc_rd_n(adc_rd_n), .adc_sel(adc_sel), .grant(grant),
    .result(result), .result_ch(result_ch), .result_valid(result_valid),
    .busy(busy), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ADC model: end-of-conversion 10 cycles after WR rises, released after first RD.
  logic       resp_en;
  logic [3:0] data_hi, data_lo;
  always begin
    @(posedge adc_wr_n);
    if (resp_en === 1'b1 && rst === 1'b0) begin
      repeat (10) @(posedge clk);
      @(negedge clk);
      adc_int_model = 1'b0;
      adc_data      = data_hi;
      @(negedge adc_rd_n);
      @(negedge clk);
      adc_int_model = 1'b1;
      @(posedge adc_rd_n);
      @(negedge clk);
      adc_data = data_lo;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  int         wr_low, rd_low, rd_pulses, gap_cyc, rv_pulses, rv_cycle, cs_hi_pre;
  int         sel_viol = 0;
  logic [2:0] grant_seen;
  logic [7:0] rv_result;
  logic [1:0] rv_ch;

  // Samples one transaction at negedges until result_valid or budget expiry.
  task automatic watch_txn(input int budget);
    logic       rd_prev, cs_prev, cs_seen_low;
    logic [1:0] sel_prev;
    wr_low = 0; rd_low = 0; rd_pulses = 0; gap_cyc = 0; rv_pulses = 0;
    rv_cycle = -1; cs_hi_pre = 0; grant_seen = 3'b000; rv_result = 8'h00; rv_ch = 2'd0;
    rd_prev = 1'b1; cs_prev = 1'b1; cs_seen_low = 1'b0; sel_prev = adc_sel;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!adc_cs_n) cs_seen_low = 1'b1;
      else if (!cs_seen_low) cs_hi_pre++;
      if (!adc_wr_n) wr_low++;
      if (!adc_rd_n) rd_low++;
      if (!adc_rd_n && rd_prev) rd_pulses++;
      if (adc_rd_n && !adc_cs_n && rd_pulses == 1) gap_cyc++;
      if (!adc_cs_n && !cs_prev && adc_sel !== sel_prev) sel_viol++;
      if (grant_seen == 3'b000) grant_seen = grant;
      rd_prev = adc_rd_n; cs_prev = adc_cs_n; sel_prev = adc_sel;
      if (result_valid) begin
        rv_pulses = 1; rv_cycle = i + 1; rv_result = result; rv_ch = result_ch;
        break;
      end
    end
  endtask

  logic [7:0] rr_data  [4] = '{8'h3C, 8'h7E, 8'h10, 8'hFF};
  logic [2:0] rr_grant [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [1:0] rr_ch    [4] = '{2'd0, 2'd1, 2'd2, 2'd0};

  initial begin
    int t_cyc, cnt_a, cnt_b;
    logic got;
    rst = 1'b1; enable = 1'b0; req = 3'b000; clear_err = 1'b0;
    resp_en = 1'b1; data_hi = 4'hA; data_lo = 4'h5;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cs_n", adc_cs_n, 1); check("rst_wr_n", adc_wr_n, 1);
    check("rst_rd_n", adc_rd_n, 1); check("rst_sel", adc_sel, 0);
    check("rst_grant", grant, 0); check("rst_result", result, 0);
    check("rst_result_ch", result_ch, 0); check("rst_rv", result_valid, 0);
    check("rst_busy", busy, 0); check("rst_terr", timeout_err, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single request, full strobe timing
    enable = 1'b1; req = 3'b001;
    watch_txn(200);
    req = 3'b000;
    check("t1_rv", rv_pulses, 1); check("t1_latency", rv_cycle, 25);
    check("t1_result", rv_result, 8'hA5); check("t1_ch", rv_ch, 0);
    check("t1_grant", grant_seen, 3'b001); check("t1_wr_low", wr_low, 4);
    check("t1_rd_low", rd_low, 4); check("t1_rd_pulses", rd_pulses, 2);
    check("t1_gap", gap_cyc, 1);
    @(negedge clk);
    check("t1_rv_one_cycle", result_valid, 0);
    @(negedge clk);
    check("t1_idle_busy", busy, 0);

    // Round robin with all requests held, from a fresh pointer
    rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      data_hi = rr_data[k][7:4]; data_lo = rr_data[k][3:0];
      watch_txn(200);
      check($sformatf("rr%0d_grant", k), grant_seen, rr_grant[k]);
      check($sformatf("rr%0d_ch", k), rv_ch, rr_ch[k]);
      check($sformatf("rr%0d_result", k), rv_result, rr_data[k]);
      if (k > 0) check($sformatf("rr%0d_idle_gap", k), cs_hi_pre, 1);
    end
    req = 3'b000;
    repeat (2) @(negedge clk);

    // Conversion timeout on ch1, then rotation continues to ch2
    resp_en = 1'b0; req = 3'b111; t_cyc = -1; rv_pulses = 0; grant_seen = 3'b000;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (grant_seen == 3'b000) grant_seen = grant;
      if (result_valid) rv_pulses++;
      if (timeout_err) begin t_cyc = i + 1; break; end
    end
    check("to_cycles", t_cyc, 1007); check("to_grant", grant_seen, 3'b010);
    check("to_no_rv", rv_pulses, 0); check("to_abort_grant", grant, 0);
    check("to_abort_cs_n", adc_cs_n, 1); check("to_result_kept", result, 8'hFF);
    resp_en = 1'b1; data_hi = 4'h2; data_lo = 4'hD;
    watch_txn(200);
    req = 3'b000;
    check("to_next_grant", grant_seen, 3'b100); check("to_next_ch", rv_ch, 2);
    check("to_next_result", rv_result, 8'h2D); check("to_sticky", timeout_err, 1);
    @(negedge clk); clear_err = 1'b1;
    @(negedge clk); clear_err = 1'b0;
    check("clear_err", timeout_err, 0);
    repeat (2) @(negedge clk);

    // clear_err in the same cycle as a new timeout: set wins
    resp_en = 1'b0; req = 3'b001; t_cyc = -1;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (i == 1005) clear_err = 1'b1;
      if (timeout_err) begin t_cyc = i + 1; break; end
    end
    clear_err = 1'b0; req = 3'b000;
    check("setwin_cycles", t_cyc, 1007);
    @(negedge clk);
    check("setwin_terr", timeout_err, 1);
    resp_en = 1'b1;
    repeat (2) @(negedge clk);

    // Reset during RD_HI on ch2
    data_hi = 4'h9; data_lo = 4'h9; req = 3'b100; got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!adc_rd_n) begin got = 1'b1; break; end
    end
    check("rd_reached", got, 1);
    check("rd_sel_before", adc_sel, 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_cs_n", adc_cs_n, 1); check("mid_rst_rd_n", adc_rd_n, 1);
    check("mid_rst_sel", adc_sel, 0); check("mid_rst_grant", grant, 0);
    check("mid_rst_busy", busy, 0); check("mid_rst_result", result, 0);
    check("mid_rst_terr", timeout_err, 0);
    cnt_a = 0;
    repeat (3) begin @(negedge clk); if (result_valid) cnt_a++; end
    check("mid_rst_no_rv", cnt_a, 0);
    rst = 1'b0; req = 3'b010; data_hi = 4'h6; data_lo = 4'h9;
    watch_txn(200);
    req = 3'b000;
    check("post_rst_rv", rv_pulses, 1); check("post_rst_ch", rv_ch, 1);
    check("post_rst_result", rv_result, 8'h69);
    repeat (2) @(negedge clk);

    // enable dropped during WAIT
    req = 3'b001; data_hi = 4'h4; data_lo = 4'hB; got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!adc_wr_n) begin got = 1'b1; break; end
    end
    for (int i = 0; i < 100 && got; i++) begin
      @(negedge clk);
      if (adc_wr_n) break;
    end
    enable = 1'b0;
    check("en_wr_seen", got, 1);
    watch_txn(200);
    check("en_drop_rv", rv_pulses, 1); check("en_drop_result", rv_result, 8'h4B);
    cnt_a = 0;
    repeat (20) begin @(negedge clk); if (busy) cnt_a++; end
    check("en_low_no_start", cnt_a, 0);
    enable = 1'b1; data_hi = 4'h8; data_lo = 4'h1;
    watch_txn(200);
    req = 3'b000;
    check("en_resume_ch", rv_ch, 0); check("en_resume_result", rv_result, 8'h81);
    repeat (2) @(negedge clk);

    // Own req falls and other reqs change mid-transaction
    req = 3'b100; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (grant != 3'b000) begin got = 1'b1; break; end
    end
    check("req_drop_grant", grant, 3'b100);
    req = 3'b011; data_hi = 4'hC; data_lo = 4'h3;
    watch_txn(200);
    check("req_drop_rv", rv_pulses, 1); check("req_drop_ch", rv_ch, 2);
    check("req_drop_result", rv_result, 8'hC3);
    data_hi = 4'hE; data_lo = 4'h7;
    watch_txn(200);
    req = 3'b000;
    check("after_drop_grant", grant_seen, 3'b001); check("after_drop_result", rv_result, 8'hE7);
    repeat (2) @(negedge clk);

    // Stuck-low ADC interrupt blocks new starts
    stuck_low = 1'b1;
    repeat (4) @(negedge clk);
    req = 3'b001; cnt_a = 0; cnt_b = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) cnt_a++;
      if (!adc_cs_n) cnt_b++;
    end
    req = 3'b000; stuck_low = 1'b0;
    check("stuck_busy", cnt_a, 0); check("stuck_cs", cnt_b, 0);
    check("sel_stable_under_cs", sel_viol, 0);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
